// File: rtl/param_fifo_pkg.sv
// Shared defaults and read-mode encoding for the parameterised FIFO.
package param_fifo_pkg;

    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_DEPTH     = 16;
    localparam int unsigned DEF_AF_THRESH = DEF_DEPTH - 2;
    localparam int unsigned DEF_AE_THRESH = 2;

    typedef enum logic {
        STD  = 1'b0,
        FWFT = 1'b1
    } read_mode_e;

endpackage

// File: rtl/param_fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module param_fifo_mem #(
    parameter int unsigned DATA_W = param_fifo_pkg::DEF_DATA_W,
    parameter int unsigned DEPTH  = param_fifo_pkg::DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_fifo.sv
// Synchronous FIFO with standard or first-word-fall-through read mode; occupancy
// is tracked by a registered count from which every status flag is derived.
module param_fifo #(
    parameter int unsigned DATA_W    = param_fifo_pkg::DEF_DATA_W,
    parameter int unsigned DEPTH     = param_fifo_pkg::DEF_DEPTH,
    parameter int unsigned FWFT      = 0,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = param_fifo_pkg::DEF_AE_THRESH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      din,
    input  logic                   wr_en,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      dout,
    output logic                   valid,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] data_count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam param_fifo_pkg::read_mode_e Mode =
        (FWFT != 0) ? param_fifo_pkg::FWFT : param_fifo_pkg::STD;

    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              wr_acc, rd_acc;
    logic              overflow_q, underflow_q;
    logic [DATA_W-1:0] rdata;

    // Full rejects the write but still lets a read through; empty is the mirror case.
    always_comb begin
        wr_acc  = wr_en & ~full;
        rd_acc  = rd_en & ~empty;
        count_d = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q     <= count_d;
            overflow_q  <= wr_en & full;
            underflow_q <= rd_en & empty;
        end
    end

    assign empty        = (count_q == '0);
    assign full         = (count_q == CW'(DEPTH));
    assign almost_full  = (count_q >= CW'(AF_THRESH));
    assign almost_empty = (count_q <= CW'(AE_THRESH));
    assign data_count   = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    param_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (din),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    if (Mode == param_fifo_pkg::FWFT) begin : g_fwft
        assign dout  = rdata;
        assign valid = ~empty;
    end else begin : g_std
        logic [DATA_W-1:0] dout_q;
        logic              valid_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                dout_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= rd_acc;
                if (rd_acc) begin
                    dout_q <= rdata;
                end
            end
        end

        assign dout  = dout_q;
        assign valid = valid_q;
    end

endmodule

// File: tb/tb_param_fifo.sv
// Scoreboard bench: standard-mode and FWFT instances driven with directed and random traffic.
module tb_param_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       wr_en, rd_en;
    logic [7:0] dout;
    logic       valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] data_count;

    logic [7:0] f_din;
    logic       f_wr, f_rd;
    logic [7:0] f_dout;
    logic       f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [4:0] f_cnt;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] m_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] m_last;

    param_fifo #(
        .DATA_W(8), .DEPTH(16), .FWFT(0), .AF_THRESH(14), .AE_THRESH(2)
    ) dut_std (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en), .dout(dout),
        .valid(valid), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .data_count(data_count), .overflow(overflow),
        .underflow(underflow)
    );

    param_fifo #(
        .DATA_W(8), .DEPTH(16), .FWFT(1), .AF_THRESH(14), .AE_THRESH(2)
    ) dut_fwft (
        .clk(clk), .rst(rst), .din(f_din), .wr_en(f_wr), .rd_en(f_rd), .dout(f_dout),
        .valid(f_valid), .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .data_count(f_cnt), .overflow(f_ovf), .underflow(f_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Read-data monitor: every valid word must match the oldest outstanding expected word.
    always @(negedge clk) begin
        if (rst && valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_valid: got dout %0d, expected no valid", dout);
            end else begin
                chk("rd_data", {24'd0, dout}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic check_state(input bit ovf, input bit unf, input bit vld);
        int n;
        n = m_q.size();
        chk("data_count", {27'd0, data_count}, n);
        chk("full", {31'd0, full}, {31'd0, n == 16});
        chk("empty", {31'd0, empty}, {31'd0, n == 0});
        chk("almost_full", {31'd0, almost_full}, {31'd0, n >= 14});
        chk("almost_empty", {31'd0, almost_empty}, {31'd0, n <= 2});
        chk("overflow", {31'd0, overflow}, {31'd0, ovf});
        chk("underflow", {31'd0, underflow}, {31'd0, unf});
        chk("valid", {31'd0, valid}, {31'd0, vld});
        chk("dout_hold", {24'd0, dout}, {24'd0, m_last});
    endtask

    task automatic step(input bit w, input bit r, input logic [7:0] d);
        bit wa, ra, ovf, unf;
        wr_en = w;
        rd_en = r;
        din   = d;
        wa  = w && (m_q.size() != 16);
        ra  = r && (m_q.size() != 0);
        ovf = w && (m_q.size() == 16);
        unf = r && (m_q.size() == 0);
        @(posedge clk);
        #1;
        if (ra) begin
            m_last = m_q.pop_front();
            exp_q.push_back(m_last);
        end
        if (wa) m_q.push_back(d);
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_state(ovf, unf, ra);
    endtask

    task automatic fstep(input bit w, input bit r, input logic [7:0] d);
        f_wr  = w;
        f_rd  = r;
        f_din = d;
        @(posedge clk);
        #1;
        f_wr = 1'b0;
        f_rd = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        din = '0; wr_en = 1'b0; rd_en = 1'b0;
        f_din = '0; f_wr = 1'b0; f_rd = 1'b0;
        m_last = '0;
        #12;
        check_state(1'b0, 1'b0, 1'b0);
        chk("fwft_reset_valid", {31'd0, f_valid}, 0);
        chk("fwft_reset_empty", {31'd0, f_empty}, 1);
        @(negedge clk);
        rst = 1'b1;

        // Single word round trip
        step(1, 0, 8'd25);
        step(0, 1, 8'd0);
        chk("rt_dout", {24'd0, dout}, 25);
        step(0, 0, 8'd0);
        chk("rt_empty", {31'd0, empty}, 1);

        // Fill to full, overflow, drain in order
        for (int i = 0; i < 16; i++) step(1, 0, 8'(i));
        chk("fill_full", {31'd0, full}, 1);
        step(1, 0, 8'd99);
        chk("ovf_count", {27'd0, data_count}, 16);
        step(0, 0, 8'd0);
        for (int i = 0; i < 16; i++) step(0, 1, 8'd0);
        chk("drain_last", {24'd0, dout}, 15);

        // Underflow on empty read
        step(0, 1, 8'd0);
        chk("unf_dout", {24'd0, dout}, 15);
        step(0, 0, 8'd0);

        // Simultaneous requests at full and at empty
        for (int i = 0; i < 16; i++) step(1, 0, 8'(100 + i));
        step(1, 1, 8'd77);
        chk("both_full_count", {27'd0, data_count}, 15);
        for (int i = 0; i < 15; i++) step(0, 1, 8'd0);
        step(1, 1, 8'd88);
        chk("both_empty_count", {27'd0, data_count}, 1);
        step(0, 1, 8'd0);
        step(0, 0, 8'd0);

        // Asynchronous reset mid-burst
        for (int i = 0; i < 10; i++) step(1, 0, 8'(200 + i));
        wr_en = 1'b1;
        din   = 8'd222;
        #2;
        rst = 1'b0;
        #1;
        m_q.delete();
        m_last = '0;
        wr_en  = 1'b0;
        check_state(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        step(1, 0, 8'd50);
        step(0, 1, 8'd0);
        chk("post_rst_dout", {24'd0, dout}, 50);

        // Random traffic, alternating write-heavy and read-heavy phases
        for (int i = 0; i < 1000; i++) begin
            int bias;
            bias = ((i / 100) % 2 == 0) ? 70 : 30;
            step($urandom_range(0, 99) < bias, $urandom_range(0, 99) >= bias,
                 8'($urandom_range(0, 255)));
        end
        while (m_q.size() != 0) step(0, 1, 8'd0);
        step(0, 0, 8'd0);

        // FWFT instance
        fstep(1, 0, 8'd40);
        chk("fwft_first_dout", {24'd0, f_dout}, 40);
        chk("fwft_first_valid", {31'd0, f_valid}, 1);
        fstep(1, 0, 8'd41);
        chk("fwft_head_hold", {24'd0, f_dout}, 40);
        chk("fwft_count2", {27'd0, f_cnt}, 2);
        fstep(0, 1, 8'd0);
        chk("fwft_next", {24'd0, f_dout}, 41);
        chk("fwft_next_valid", {31'd0, f_valid}, 1);
        fstep(0, 1, 8'd0);
        chk("fwft_empty", {31'd0, f_empty}, 1);
        chk("fwft_valid_low", {31'd0, f_valid}, 0);
        chk("fwft_flags", {28'd0, f_full, f_af, f_ovf, f_unf}, 0);
        chk("fwft_ae", {31'd0, f_ae}, 1);

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter: DATA_W, 8, data word width in bits.
REQ-002 Parameter: DEPTH, 16, entry count; power of two, at least 4.
REQ-003 Parameter: FWFT, 0, read mode: 0 = standard (registered dout), 1 = first-word-fall-through.
REQ-004 Parameter: AF_THRESH, DEPTH-2, almost_full asserts when data_count >= AF_THRESH.
REQ-005 Parameter: AE_THRESH, 2, almost_empty asserts when data_count <= AE_THRESH.
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 rst  in  1  asynchronous active-low reset; asserted when 0.
REQ-008 din  in  DATA_W  write data.
REQ-009 wr_en  in  1  write request.
REQ-010 rd_en  in  1  read request.
REQ-011 dout  out  DATA_W  read data.
REQ-012 valid  out  1  dout holds a word read from the FIFO.
REQ-013 full / empty  out  1 each  occupancy is DEPTH / occupancy is 0.
REQ-014 almost_full / almost_empty  out  1 each  threshold flags per REQ-004/005.
REQ-015 data_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-016 overflow / underflow  out  1 each  rejected write / rejected read indicator.

Function
REQ-017 Write accepted iff wr_en=1 and full=0; din stored at write pointer, which then increments modulo DEPTH.
REQ-018 Read accepted iff rd_en=1 and empty=0; read pointer increments modulo DEPTH.
REQ-019 Full with wr_en=1 and rd_en=1: read accepted, write rejected, overflow pulses.
REQ-020 Empty with wr_en=1 and rd_en=1: write accepted, read rejected, underflow pulses.
REQ-021 data_count: +1 on write only, -1 on read only, unchanged on both or neither; all flags derived from registered data_count.
REQ-022 Standard mode: dout registers the head word on the edge accepting the read (1-cycle latency); valid=1 for exactly that following cycle; dout holds its value otherwise.
REQ-023 FWFT mode: dout shows the head word combinationally whenever empty=0; valid = ~empty; rd_en acknowledges/pops the shown word.
REQ-024 FWFT first-word latency: word written into empty FIFO appears on dout, valid=1, the cycle after the write edge.
REQ-025 overflow and underflow are registered single-cycle pulses in the cycle after the rejected request; FIFO state unchanged by rejected requests.
REQ-026 Pointers are $clog2(DEPTH) bits and wrap naturally; no pointer-compare full/empty logic, data_count is authoritative.

Reset
REQ-027 rst=0 asynchronously forces: pointers 0, data_count 0, empty=1, almost_empty=1, full=0, almost_full=0, valid=0, overflow=0, underflow=0, standard-mode dout=0.
REQ-028 Reset mid-operation discards all contents; storage array is not reset; first accepted write after deassertion goes to entry 0.
REQ-029 Requests during the cycle of rst deassertion are honoured normally on the next rising edge.

Structure
REQ-030 Package param_fifo_pkg holds default constants (DATA_W, DEPTH, thresholds) and the read-mode enum (STD, FWFT).
REQ-031 Storage is a sub-module param_fifo_mem: simple dual-port array, synchronous write, asynchronous read, DATA_W x DEPTH.

Verification (DATA_W=8, DEPTH=16 unless stated)
REQ-032 Reset, then write 25, then read, standard mode -> dout=25 with valid=1 one cycle after rd_en edge; empty=1 afterward, data_count=0.
REQ-033 Write 16 words 0..15 -> full=1 at count 16, almost_full=1 from count 14; 17th write -> overflow pulse, count stays 16; read all -> 0..15 in order.
REQ-034 Read while empty -> underflow pulse one cycle later, dout and count unchanged.
REQ-035 Full with simultaneous wr_en/rd_en -> count 15, overflow=1; empty with both -> count 1, underflow=1.
REQ-036 FWFT=1: write 40 into empty FIFO -> dout=40, valid=1 next cycle with no rd_en; rd_en -> empty=1.
REQ-037 Write 10 words, assert rst=0 mid-burst -> all flags to reset values immediately (async); then write 50, read -> 50 returned; 1000 random write/read cycles against a scoreboard -> no mismatch, pointer wrap exercised.
